// File: rtl/mips_pkg.sv
// Shared MIPS debug definitions: dump-reader state encoding and register-file geometry.
// Pure declarations; no logic, no latency, no flow control.
package mips_pkg;

  localparam int MIPS_ADDR_NBITS = 5;
  localparam int MIPS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    SEND  = 2'b10
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready word stream from the register dump reader to the debug/trace host.
// Master holds DATA/ADDR/LAST_BEAT stable while VALID=1 and READY=0.
interface regfile_dump_reader_if
  import mips_pkg::*;
#(
  parameter int ADDR_Nbits = MIPS_ADDR_NBITS,
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH
);

  logic                  RegDump_VALID;
  logic                  RegDump_READY;
  logic [DATA_WIDTH-1:0] RegDump_DATA;
  logic [ADDR_Nbits-1:0] RegDump_ADDR;
  logic                  RegDump_LAST_BEAT;

  modport master (
    output RegDump_VALID,
    output RegDump_DATA,
    output RegDump_ADDR,
    output RegDump_LAST_BEAT,
    input  RegDump_READY
  );

  modport slave (
    input  RegDump_VALID,
    input  RegDump_DATA,
    input  RegDump_ADDR,
    input  RegDump_LAST_BEAT,
    output RegDump_READY
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks FIRST..LAST (mod 2**ADDR_Nbits), first word valid 2 edges after START, 1 word/cycle.
// Backpressure: READY=0 freezes the presented word and the read pointer; ABORT wins over any handshake.
module regfile_dump_reader
  import mips_pkg::*;
#(
  parameter int ADDR_Nbits = MIPS_ADDR_NBITS,
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH
)
(
  input  logic                  RegDump_CLK,
  input  logic                  RegDump_RST,
  input  logic                  RegDump_START,
  input  logic                  RegDump_ABORT,
  input  logic [ADDR_Nbits-1:0] RegDump_FIRST,
  input  logic [ADDR_Nbits-1:0] RegDump_LAST,
  output logic [ADDR_Nbits-1:0] RegDump_RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RegDump_RD_DATA,
  output logic                  RegDump_BUSY,
  output logic                  RegDump_DONE,
  regfile_dump_reader_if.master dump
);

  dump_state_t           state_q, state_d;
  logic [ADDR_Nbits-1:0] ptr_q,   ptr_d;
  logic [ADDR_Nbits-1:0] last_q,  last_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [ADDR_Nbits-1:0] addr_q,  addr_d;
  logic                  valid_q, valid_d;
  logic                  lbeat_q, lbeat_d;
  logic                  done_q,  done_d;
  logic                  capture;

  always_ff @(posedge RegDump_CLK or negedge RegDump_RST) begin
    if (!RegDump_RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      lbeat_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      lbeat_q <= lbeat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    lbeat_d = lbeat_q;
    done_d  = 1'b0;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        lbeat_d = 1'b0;
        if (RegDump_START) begin
          last_d  = RegDump_LAST;
          ptr_d   = RegDump_FIRST;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (RegDump_ABORT) begin
          valid_d = 1'b0;
          lbeat_d = 1'b0;
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        // Abort drops the presented word even if the host accepts it this cycle.
        if (RegDump_ABORT) begin
          valid_d = 1'b0;
          lbeat_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && dump.RegDump_READY) begin
          if (lbeat_q) begin
            valid_d = 1'b0;
            lbeat_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            capture = 1'b1;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        lbeat_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      data_d  = RegDump_RD_DATA;
      addr_d  = ptr_q;
      lbeat_d = (ptr_q == last_q);
      ptr_d   = ptr_q + ADDR_Nbits'(1);
      valid_d = 1'b1;
    end
  end

  assign RegDump_RD_ADDR        = ptr_q;
  assign RegDump_BUSY           = (state_q != IDLE);
  assign RegDump_DONE           = done_q;
  assign dump.RegDump_VALID     = valid_q;
  assign dump.RegDump_DATA      = data_q;
  assign dump.RegDump_ADDR      = addr_q;
  assign dump.RegDump_LAST_BEAT = lbeat_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of dump ranges/READY patterns plus abort and reset sequences.
module tb_regfile_dump_reader;
  import mips_pkg::*;

  localparam int AW = MIPS_ADDR_NBITS;
  localparam int DW = MIPS_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort_r = 1'b0;
  logic [AW-1:0] first = '0;
  logic [AW-1:0] last = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] rf [32];

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  regfile_dump_reader_if #(.ADDR_Nbits(AW), .DATA_WIDTH(DW)) dif ();

  regfile_dump_reader #(.ADDR_Nbits(AW), .DATA_WIDTH(DW)) dut (
    .RegDump_CLK     (clk),
    .RegDump_RST     (rst_n),
    .RegDump_START   (start),
    .RegDump_ABORT   (abort_r),
    .RegDump_FIRST   (first),
    .RegDump_LAST    (last),
    .RegDump_RD_ADDR (rd_addr),
    .RegDump_RD_DATA (rd_data),
    .RegDump_BUSY    (busy),
    .RegDump_DONE    (done),
    .dump            (dif.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [7:0]    rdy_pat;
    int            exp_cnt;
    int            exp_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return {16'hA5A5, 11'h000, a};
  endfunction

  task automatic run_dump(input vec_t v);
    int            k = 0;
    int            idx = 0;
    int            cyc = 0;
    int            budget = 0;
    bit            done_seen = 0;
    logic [AW-1:0] ea;
    first = v.first;
    last  = v.last;
    start = 1'b1;
    step();
    cyc   = 1;
    start = 1'b0;
    // Scramble the range inputs: the latched copies must be used from here on.
    first = ~v.first;
    last  = ~v.last;
    chk("busy_after_start", busy, 1);
    while (!done_seen && budget < 300) begin
      dif.RegDump_READY = v.rdy_pat[idx[2:0]];
      if (dif.RegDump_VALID) begin
        ea = v.first + AW'(k);
        chk("beat_addr", dif.RegDump_ADDR, ea);
        chk("beat_data", dif.RegDump_DATA, exp_word(ea));
        chk("beat_last", dif.RegDump_LAST_BEAT, (k == v.exp_cnt - 1));
        if (dif.RegDump_READY) k++;
        idx++;
      end
      step();
      cyc++;
      budget++;
      if (done) done_seen = 1;
    end
    chk("done_seen", done_seen, 1);
    chk("beat_count", k, v.exp_cnt);
    chk("start_to_done_cycles", cyc, v.exp_cyc);
    chk("valid_after_done", dif.RegDump_VALID, 0);
    chk("busy_after_done", busy, 0);
    dif.RegDump_READY = 1'b0;
    step();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA5A5_0000 + i;
    dif.RegDump_READY = 1'b0;

    vecs[0] = '{first: 5'd0,  last: 5'd31, rdy_pat: 8'hFF, exp_cnt: 32, exp_cyc: 34};
    vecs[1] = '{first: 5'd4,  last: 5'd7,  rdy_pat: 8'hE9, exp_cnt: 4,  exp_cyc: 9};
    vecs[2] = '{first: 5'd30, last: 5'd1,  rdy_pat: 8'hFF, exp_cnt: 4,  exp_cyc: 6};
    vecs[3] = '{first: 5'd9,  last: 5'd9,  rdy_pat: 8'hFF, exp_cnt: 1,  exp_cyc: 3};
    vecs[4] = '{first: 5'd31, last: 5'd0,  rdy_pat: 8'h55, exp_cnt: 2,  exp_cyc: 5};

    #12;
    chk("rst_valid", dif.RegDump_VALID, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", dif.RegDump_DATA, 0);
    chk("rst_addr", dif.RegDump_ADDR, 0);
    chk("rst_last_beat", dif.RegDump_LAST_BEAT, 0);
    chk("rst_rd_addr", rd_addr, 0);
    #8;
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) run_dump(vecs[v]);

    // Abort on the third beat of a full dump, with a START pulse while busy.
    first = 5'd0;
    last  = 5'd31;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ab_first_addr", dif.RegDump_ADDR, 0);
    dif.RegDump_READY = 1'b1;
    step();
    chk("ab_second_addr", dif.RegDump_ADDR, 1);
    start = 1'b1;
    first = 5'd20;
    step();
    start = 1'b0;
    chk("start_while_busy_ignored", dif.RegDump_ADDR, 2);
    chk("ab_third_data", dif.RegDump_DATA, exp_word(5'd2));
    abort_r = 1'b1;
    step();
    chk("ab_valid", dif.RegDump_VALID, 0);
    chk("ab_busy", busy, 0);
    chk("ab_no_done", done, 0);
    chk("ab_last_beat", dif.RegDump_LAST_BEAT, 0);

    // START and ABORT together in IDLE: START wins.
    start = 1'b1;
    first = 5'd9;
    last  = 5'd9;
    dif.RegDump_READY = 1'b0;
    step();
    chk("start_over_abort_busy", busy, 1);
    chk("start_over_abort_rd_addr", rd_addr, 9);
    start   = 1'b0;
    abort_r = 1'b0;
    step();
    chk("single_valid", dif.RegDump_VALID, 1);
    chk("single_addr", dif.RegDump_ADDR, 9);
    chk("single_last_beat", dif.RegDump_LAST_BEAT, 1);

    // ABORT together with the final handshake: no DONE.
    abort_r = 1'b1;
    dif.RegDump_READY = 1'b1;
    step();
    chk("sim_no_done", done, 0);
    chk("sim_valid", dif.RegDump_VALID, 0);
    chk("sim_busy", busy, 0);
    abort_r = 1'b0;
    dif.RegDump_READY = 1'b0;
    step();
    chk("sim_no_late_done", done, 0);

    // Asynchronous reset while a word is presented.
    first = 5'd3;
    last  = 5'd31;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre_rst_valid", dif.RegDump_VALID, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", dif.RegDump_VALID, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", dif.RegDump_DATA, 0);
    chk("mid_rst_addr", dif.RegDump_ADDR, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", dif.RegDump_VALID, 0);
    chk("post_rst_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
